avalon_sdram_slave: RTL and testbench

- 16-bit Avalon-MM pipelined responder backed by a 2^ADDR_W-word on-chip register array.
- Acts as the slave end of the master-side read/write protocol (read_n/write_n/chipselect/waitrequest/readdatavalid).
- Used as a bench-and-FPGA stand-in for the SDRAM controller port: programmable wait states, fixed read latency and a bounded number of outstanding reads.

---
 rtl/avalon_sdram_slave.sv | 125 ++++++++++++
 tb/tb_avalon_sdram_slave.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/avalon_sdram_slave.sv
// Avalon-MM pipelined slave with a register-array backing store, used in place of an SDRAM port.
// Provides programmable wait states, a fixed read latency and a cap on outstanding reads.
module avalon_sdram_slave #(
  parameter int ADDR_W       = 4,
  parameter int WAIT_STATES  = 1,
  parameter int READ_LATENCY = 3,
  parameter int MAX_PENDING  = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        chipselect,
  input  logic        read_n,
  input  logic        write_n,
  input  logic [31:0] address,
  input  logic [1:0]  byteenable,
  input  logic [15:0] writedata,
  output logic        waitrequest,
  output logic        readdatavalid,
  output logic [15:0] readdata,
  output logic        addr_err
);

  localparam int         DEPTH = 1 << ADDR_W;
  localparam logic [2:0] WS    = 3'(WAIT_STATES);
  localparam logic [3:0] MAXP  = 4'(MAX_PENDING);

  logic [2:0]              wcnt_reg, wcnt_next;
  logic [3:0]              pending_reg, pending_next;
  logic [15:0]             mem_reg [DEPTH];
  logic [READ_LATENCY-1:0] vld_reg;
  logic [15:0]             data_reg [READ_LATENCY];
  logic                    rdv_reg;
  logic [15:0]             rdata_reg;
  logic                    addr_err_reg;

  logic              cmd, is_wr, in_range, accept, rd_accept, wr_accept;
  logic [ADDR_W-1:0] idx;
  logic [15:0]       rd_word;
  logic [1:0]        lane_we;

  assign cmd       = chipselect & (~read_n | ~write_n);
  assign is_wr     = ~write_n;
  assign in_range  = (address[31:ADDR_W] == '0);
  assign idx       = address[ADDR_W-1:0];
  // A full read queue only stalls reads; writes proceed once their wait states elapse.
  assign waitrequest = cmd & ((wcnt_reg != WS) | (~is_wr & (pending_reg == MAXP)));
  assign accept      = cmd & ~waitrequest;
  assign rd_accept   = accept & ~is_wr;
  assign wr_accept   = accept & is_wr;
  assign rd_word     = in_range ? mem_reg[idx] : 16'h0000;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_lane
      assign lane_we[gi] = wr_accept & in_range & byteenable[gi];
    end
  endgenerate

  always_comb begin
    wcnt_next = wcnt_reg;
    if (!cmd || accept)
      wcnt_next = '0;
    else if (wcnt_reg < WS)
      wcnt_next = wcnt_reg + 3'd1;
  end

  // A return can only occur for a previously accepted read, so the decrement never underflows.
  always_comb begin
    pending_next = pending_reg;
    case ({rd_accept, rdv_reg})
      2'b10:   pending_next = pending_reg + 4'd1;
      2'b01:   pending_next = pending_reg - 4'd1;
      default: pending_next = pending_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wcnt_reg     <= '0;
      pending_reg  <= '0;
      addr_err_reg <= 1'b0;
    end else begin
      wcnt_reg    <= wcnt_next;
      pending_reg <= pending_next;
      if (accept && !in_range)
        addr_err_reg <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++)
        mem_reg[i] <= '0;
    end else begin
      if (lane_we[0]) mem_reg[idx][7:0]  <= writedata[7:0];
      if (lane_we[1]) mem_reg[idx][15:8] <= writedata[15:8];
    end
  end

  // Read word is captured at accept and walks a fixed-length shift pipeline.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_reg   <= '0;
      for (int i = 0; i < READ_LATENCY; i++)
        data_reg[i] <= '0;
      rdv_reg   <= 1'b0;
      rdata_reg <= '0;
    end else begin
      vld_reg[0] <= rd_accept;
      if (rd_accept)
        data_reg[0] <= rd_word;
      for (int i = 1; i < READ_LATENCY; i++) begin
        vld_reg[i]  <= vld_reg[i-1];
        data_reg[i] <= data_reg[i-1];
      end
      rdv_reg <= vld_reg[READ_LATENCY-1];
      if (vld_reg[READ_LATENCY-1])
        rdata_reg <= data_reg[READ_LATENCY-1];
    end
  end

  assign readdatavalid = rdv_reg;
  assign readdata      = rdata_reg;
  assign addr_err      = addr_err_reg;

endmodule

// File: tb/tb_avalon_sdram_slave.sv
// Directed bench for avalon_sdram_slave: wait states, read latency, byte lanes, read throttling,
// out-of-range handling, reset mid-flight and simultaneous read/write requests.
module tb_avalon_sdram_slave;
  localparam int WS = 1;
  localparam int RL = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        chipselect;
  logic        read_n;
  logic        write_n;
  logic [31:0] address;
  logic [1:0]  byteenable;
  logic [15:0] writedata;
  logic        waitrequest;
  logic        readdatavalid;
  logic [15:0] readdata;
  logic        addr_err;

  int checks = 0;
  int errors = 0;

  avalon_sdram_slave #(
    .ADDR_W(4), .WAIT_STATES(WS), .READ_LATENCY(RL), .MAX_PENDING(2)
  ) dut (
    .clk(clk), .reset(reset), .chipselect(chipselect), .read_n(read_n), .write_n(write_n),
    .address(address), .byteenable(byteenable), .writedata(writedata),
    .waitrequest(waitrequest), .readdatavalid(readdatavalid), .readdata(readdata),
    .addr_err(addr_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Presents a command, counts stalled cycles, returns just after the accepting edge.
  task automatic bus_cmd(input logic rn, input logic wn, input logic [31:0] a,
                         input logic [15:0] wd, input logic [1:0] be, output int waits);
    chipselect = 1'b1; read_n = rn; write_n = wn;
    address = a; writedata = wd; byteenable = be;
    waits = 0;
    @(negedge clk);
    while (waitrequest && waits < 50) begin
      waits++;
      @(negedge clk);
    end
    @(posedge clk); #1;
    chipselect = 1'b0; read_n = 1'b1; write_n = 1'b1; byteenable = 2'b00;
  endtask

  task automatic wr(input logic [31:0] a, input logic [15:0] d, input logic [1:0] be, input string tag);
    int w;
    bus_cmd(1'b1, 1'b0, a, d, be, w);
    check({tag, "_waits"}, w, WS);
    $display("write %s addr=%0h data=%h be=%b waits=%0d", tag, a, d, be, w);
  endtask

  task automatic rd_expect(input logic [31:0] a, input logic [15:0] exp, input string tag);
    int w;
    int cnt;
    bus_cmd(1'b0, 1'b1, a, 16'h0000, 2'b11, w);
    check({tag, "_waits"}, w, WS);
    cnt = 0;
    do begin
      @(posedge clk); #1;
      cnt++;
    end while (!readdatavalid && cnt < 20);
    check({tag, "_latency"}, cnt, RL);
    check({tag, "_data"}, readdata, exp);
    @(posedge clk); #1;
    check({tag, "_strobe"}, readdatavalid, 1'b0);
    check({tag, "_hold"}, readdata, exp);
    $display("read  %s addr=%0h data=%h latency=%0d waits=%0d", tag, a, readdata, cnt, w);
  endtask

  initial begin
    logic [15:0] beats [4];
    int          rw [4];
    int          nb;
    int          w;
    int          seen;

    reset = 1'b1; chipselect = 1'b0; read_n = 1'b1; write_n = 1'b1;
    address = '0; byteenable = 2'b00; writedata = '0;
    repeat (2) @(posedge clk);
    #1;
    chipselect = 1'b1; read_n = 1'b0;
    #1;
    check("wait_in_reset", waitrequest, 1'b1);
    chipselect = 1'b0; read_n = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    check("rst_rdv", readdatavalid, 1'b0);
    check("rst_readdata", readdata, 16'h0000);
    check("rst_addr_err", addr_err, 1'b0);
    check("rst_wait_idle", waitrequest, 1'b0);
    $display("reset done");

    wr(32'd3, 16'hA5A5, 2'b11, "w3");
    rd_expect(32'd3, 16'hA5A5, "r3");

    wr(32'd5, 16'h1234, 2'b11, "w5");
    wr(32'd5, 16'hFF00, 2'b01, "w5_lo");
    rd_expect(32'd5, 16'h1200, "r5_merge");
    wr(32'd5, 16'hFFFF, 2'b00, "w5_none");
    rd_expect(32'd5, 16'h1200, "r5_be00");
    check("addr_err_clean", addr_err, 1'b0);

    rd_expect(32'h0000_0010, 16'h0000, "r_oob");
    check("addr_err_set", addr_err, 1'b1);
    wr(32'h0000_0010, 16'hBEEF, 2'b11, "w_oob");
    check("addr_err_sticky", addr_err, 1'b1);
    rd_expect(32'd0, 16'h0000, "r_noalias");

    wr(32'd0, 16'h1111, 2'b11, "w0");
    wr(32'd1, 16'h2222, 2'b11, "w1");
    wr(32'd2, 16'h3333, 2'b11, "w2");
    nb = 0;
    fork
      begin
        for (int i = 0; i < 4; i++) bus_cmd(1'b0, 1'b1, 32'(i), 16'h0000, 2'b11, rw[i]);
      end
      begin
        for (int c = 0; c < 60 && nb < 4; c++) begin
          @(posedge clk); #1;
          if (readdatavalid) begin
            beats[nb] = readdata;
            nb++;
          end
        end
      end
    join
    check("b2b_beats", nb, 4);
    check("b2b_w0", rw[0], 1);
    check("b2b_w1", rw[1], 1);
    check("b2b_w2_stall", rw[2], 2);
    check("b2b_w3", rw[3], 1);
    check("b2b_d0", beats[0], 16'h1111);
    check("b2b_d1", beats[1], 16'h2222);
    check("b2b_d2", beats[2], 16'h3333);
    check("b2b_d3", beats[3], 16'hA5A5);
    $display("b2b waits=%0d,%0d,%0d,%0d beats=%h,%h,%h,%h",
             rw[0], rw[1], rw[2], rw[3], beats[0], beats[1], beats[2], beats[3]);

    bus_cmd(1'b0, 1'b1, 32'd3, 16'h0000, 2'b11, w);
    check("rst_flight_waits", w, WS);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("rst_flight_addr_err", addr_err, 1'b0);
    check("rst_flight_readdata", readdata, 16'h0000);
    seen = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (readdatavalid) seen++;
    end
    check("rst_flight_no_rdv", seen, 0);
    $display("reset mid-read: stray beats=%0d", seen);
    rd_expect(32'd3, 16'h0000, "r3_after_rst");

    bus_cmd(1'b0, 1'b0, 32'd7, 16'h00C3, 2'b11, w);
    check("rw_both_waits", w, WS);
    seen = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (readdatavalid) seen++;
    end
    check("rw_both_no_rdv", seen, 0);
    $display("read+write addr=7 data=00c3 waits=%0d stray beats=%0d", w, seen);
    rd_expect(32'd7, 16'h00C3, "r7");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
